// File: rtl/button_ctrl.sv
// button_ctrl: debounces four raw buttons and turns presses into single-cycle
// commands for the tetris core, with auto-repeat on down/left/right.
//
// Ports:
//   clk        in   sole clock, all state on rising edge
//   resetn     in   asynchronous active-low reset
//   btn_up     in   raw rotate button (async, bouncy, active-high)
//   btn_down   in   raw soft-drop button
//   btn_left   in   raw move-left button
//   btn_right  in   raw move-right button
//   up         out  one-cycle rotate pulse (never repeats)
//   down       out  one-cycle drop pulse (auto-repeats while held)
//   left       out  one-cycle move-left pulse (auto-repeats while held)
//   right      out  one-cycle move-right pulse (auto-repeats while held)
module button_ctrl #(
    parameter int DEB_CYC   = 500000,
    parameter int RPT_DELAY = 12500000,
    parameter int RPT_RATE  = 2500000,
    parameter int CW        = 24
) (
    input  logic clk,
    input  logic resetn,
    input  logic btn_up,
    input  logic btn_down,
    input  logic btn_left,
    input  logic btn_right,
    output logic up,
    output logic down,
    output logic left,
    output logic right
);
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    // bit order throughout: 0 up, 1 down, 2 left, 3 right
    logic [3:0]    raw, s1, s2, deb, deb_d, rise, o;
    logic [CW-1:0] dcnt [4];
    logic [CW-1:0] rcnt [1:3];
    state_t        st   [1:3];
    logic          both;

    assign raw  = {btn_right, btn_left, btn_down, btn_up};
    assign rise = deb & ~deb_d;
    // left and right held together cancel each other's repeat
    assign both = deb[2] & deb[3];
    assign {right, left, down, up} = o;

    // synchronizer and debounce: the debounced state flips only after
    // DEB_CYC consecutive cycles of disagreement with the synchronized input
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1    <= '0;
            s2    <= '0;
            deb   <= '0;
            deb_d <= '0;
            for (int i = 0; i < 4; i++) dcnt[i] <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            deb_d <= deb;
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == deb[i]) dcnt[i] <= '0;
                else if (dcnt[i] == CW'(DEB_CYC - 1)) begin
                    deb[i]  <= ~deb[i];
                    dcnt[i] <= '0;
                end else dcnt[i] <= dcnt[i] + 1'b1;
            end
        end
    end

    // output pulses and per-button repeat FSMs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            o <= '0;
            for (int i = 1; i < 4; i++) begin
                st[i]   <= IDLE;
                rcnt[i] <= '0;
            end
        end else begin
            o[0] <= rise[0];
            for (int i = 1; i < 4; i++) begin
                o[i] <= 1'b0;
                if (st[i] == IDLE) begin
                    if (rise[i]) begin
                        o[i]    <= 1'b1;
                        st[i]   <= DELAY;
                        rcnt[i] <= '0;
                    end
                end else if (!deb[i]) begin
                    st[i]   <= IDLE;
                    rcnt[i] <= '0;
                end else if (i > 1 && both) begin
                    // parked so that repeating restarts with a full delay
                    st[i]   <= DELAY;
                    rcnt[i] <= '0;
                end else if (rcnt[i] == (st[i] == DELAY ? CW'(RPT_DELAY - 1) : CW'(RPT_RATE - 1))) begin
                    // gate against a back-to-back pulse when RPT_DELAY is 1
                    o[i]    <= ~o[i];
                    st[i]   <= REPEAT;
                    rcnt[i] <= '0;
                end else rcnt[i] <= rcnt[i] + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_button_ctrl.sv
// tb_button_ctrl: directed and randomized checks of button_ctrl against a
// timeline-based reference model.
module tb_button_ctrl;
    localparam int DEB = 4, RD = 20, RR = 8;

    logic clk = 1'b0, resetn = 1'b0;
    logic [3:0] raw = '0;
    logic up, down, left, right;

    always #5 clk = ~clk;

    button_ctrl #(.DEB_CYC(DEB), .RPT_DELAY(RD), .RPT_RATE(RR), .CW(8)) dut (
        .clk(clk), .resetn(resetn),
        .btn_up(raw[0]), .btn_down(raw[1]), .btn_left(raw[2]), .btn_right(raw[3]),
        .up(up), .down(down), .left(left), .right(right)
    );

    int tests = 0, fails = 0, ec = 0, cyc = 0;
    logic [3:0] m_s1, m_s2, m_deb, m_debd, prev;
    int streak [4];
    bit act [4];
    int anchor [4];
    int np [4];
    int lq [$], rq [$], dq [$];

    function automatic logic [3:0] outs();
        return {right, left, down, up};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_s1 = '0; m_s2 = '0; m_deb = '0; m_debd = '0; prev = '0;
        for (int i = 0; i < 4; i++) begin
            streak[i] = 0; act[i] = 0; anchor[i] = 0;
        end
    endtask

    // one clock edge: advance the model, then compare DUT outputs
    task automatic step();
        logic [3:0] exp, rise, nd;
        bit both;
        int k;
        @(posedge clk);
        ec++; cyc++;
        rise = m_deb & ~m_debd;
        both = m_deb[2] & m_deb[3];
        exp = '0;
        exp[0] = rise[0];
        for (int i = 1; i < 4; i++) begin
            if (!act[i]) begin
                if (rise[i]) begin exp[i] = 1'b1; act[i] = 1; anchor[i] = cyc; end
            end else if (!m_deb[i]) act[i] = 0;
            else if (i > 1 && both) anchor[i] = cyc;
            else begin
                k = cyc - anchor[i];
                if (k >= RD && (k - RD) % RR == 0) exp[i] = 1'b1;
            end
        end
        nd = m_deb;
        for (int i = 0; i < 4; i++) begin
            if (m_s2[i] != m_deb[i]) begin
                streak[i]++;
                if (streak[i] == DEB) begin nd[i] = ~nd[i]; streak[i] = 0; end
            end else streak[i] = 0;
        end
        m_debd = m_deb; m_deb = nd; m_s2 = m_s1; m_s1 = raw;
        #1;
        chk("outputs", 32'(outs()), 32'(exp));
        chk("back_to_back", 32'(outs() & prev), 32'h0);
        prev = outs();
        for (int i = 0; i < 4; i++) if (prev[i]) np[i]++;
        if (left) lq.push_back(ec);
        if (right) rq.push_back(ec);
        if (down) dq.push_back(ec);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input int n);
        resetn = 1'b0;
        #1;
        chk("reset_immediate", 32'(outs()), 32'h0);
        model_clear();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
            #1;
            chk("during_reset", 32'(outs()), 32'h0);
        end
        resetn = 1'b1;
    endtask

    int base, cnt [4], cur [4];

    initial begin
        model_clear();
        for (int i = 0; i < 4; i++) np[i] = 0;
        #2;
        chk("reset_state", 32'(outs()), 32'h0);
        do_reset(3);
        run(10);

        // hold left: pulses at 7, 27, 35, 43 then nothing after release
        ec = 0; lq.delete();
        raw[2] = 1'b1;
        run(44);
        raw[2] = 1'b0;
        run(30);
        chk("left_count", lq.size(), 4);
        if (lq.size() == 4) begin
            chk("left_p0", lq[0], 7);
            chk("left_p1", lq[1], 27);
            chk("left_p2", lq[2], 35);
            chk("left_p3", lq[3], 43);
        end

        // up glitch then long hold
        base = np[0];
        raw[0] = 1'b1; run(3);
        raw[0] = 1'b0; run(20);
        chk("up_glitch", np[0] - base, 0);
        raw[0] = 1'b1; run(200);
        raw[0] = 1'b0; run(20);
        chk("up_hold", np[0] - base, 1);

        // left+right together, then drop right
        ec = 0; lq.delete(); rq.delete();
        raw[3:2] = 2'b11;
        run(60);
        chk("lr_left_count", lq.size(), 1);
        chk("lr_right_count", rq.size(), 1);
        if (lq.size() > 0) chk("lr_left_edge", lq[0], 7);
        if (rq.size() > 0) chk("lr_right_edge", rq[0], 7);
        ec = 0; lq.delete();
        raw[3] = 1'b0;
        run(40);
        chk("lr_resume_present", lq.size() > 0, 1);
        if (lq.size() > 0) chk("lr_resume_edge", lq[0], 26);
        raw[2] = 1'b0;
        run(20);

        // down held through a reset pulse mid-DELAY
        ec = 0; dq.delete();
        raw[1] = 1'b1;
        run(14);
        chk("down_initial", dq.size(), 1);
        do_reset(2);
        ec = 0; dq.delete();
        run(30);
        chk("down_after_reset_present", dq.size() > 0, 1);
        if (dq.size() > 0) chk("down_after_reset_edge", dq[0], DEB + 3);
        raw[1] = 1'b0;
        run(20);

        // short random bounces never pass the debouncer
        base = np[0] + np[1] + np[2] + np[3];
        for (int i = 0; i < 4; i++) begin cur[i] = 0; cnt[i] = 0; end
        for (int n = 0; n < 10000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (cnt[i] == 0) begin cur[i] = 1 - cur[i]; cnt[i] = int'($urandom_range(1, 3)); end
                raw[i] = cur[i][0];
                cnt[i]--;
            end
            step();
        end
        raw = '0;
        run(20);
        chk("bounce_pulses", np[0] + np[1] + np[2] + np[3] - base, 0);

        // random long presses checked edge by edge against the model
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) if ($urandom_range(0, 39) == 0) raw[i] = ~raw[i];
            step();
        end
        raw = '0;
        run(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/button_ctrl.md
BUTTON_CTRL -- requirements
Module: button_ctrl

Interface
REQ-001 Parameter DEB_CYC, default 500000, consecutive cycles a synchronized input must differ from its debounced state before that state changes (legal range >=1).
REQ-002 Parameter RPT_DELAY, default 12500000, cycles from the initial press pulse to the first auto-repeat pulse (legal range >=1).
REQ-003 Parameter RPT_RATE, default 2500000, cycles between subsequent auto-repeat pulses (legal range >=2).
REQ-004 Parameter CW, default 24, width of every internal counter; must hold max(DEB_CYC, RPT_DELAY, RPT_RATE).
REQ-005 clk  input  1  sole clock; all state on its rising edge.
REQ-006 resetn  input  1  reset, asynchronous, active-low.
REQ-007 btn_up  input  1  raw rotate button, active-high, asynchronous to clk, may bounce.
REQ-008 btn_down  input  1  raw soft-drop button, same properties.
REQ-009 btn_left  input  1  raw move-left button, same properties.
REQ-010 btn_right  input  1  raw move-right button, same properties.
REQ-011 up  output  1  single-cycle rotate command to the tetris core.
REQ-012 down  output  1  single-cycle drop command to the tetris core.
REQ-013 left  output  1  single-cycle move-left command to the tetris core.
REQ-014 right  output  1  single-cycle move-right command to the tetris core.

Function
REQ-015 Each raw input SHALL pass through a 2-flop synchronizer; no other logic may sample raw inputs.
REQ-016 Per button, a debounce counter SHALL increment each cycle the synchronized value differs from the debounced state, clear to 0 on any match cycle, and on the DEB_CYC-th consecutive mismatch cycle toggle the debounced state and clear.
REQ-017 A debounced rising edge SHALL produce one registered output pulse; total latency = DEB_CYC+3 rising edges from the first edge on which the raw input is sampled high.
REQ-018 A debounced falling edge SHALL produce no pulse.
REQ-019 Bounces shorter than DEB_CYC cycles SHALL produce no state change and no pulse.
REQ-020 up SHALL never auto-repeat; one press yields exactly one pulse regardless of hold time.
REQ-021 down, left, right SHALL each run a repeat FSM with states IDLE, DELAY, REPEAT.
REQ-022 IDLE -> DELAY on debounced rise (initial pulse issued), counter cleared.
REQ-023 DELAY: counter increments each cycle; at count RPT_DELAY issue pulse, clear counter, -> REPEAT.
REQ-024 REPEAT: counter increments; at count RPT_RATE issue pulse, clear counter, stay in REPEAT.
REQ-025 Any state -> IDLE, counter cleared, no pulse, in the cycle the debounced state falls.
REQ-026 While left and right are both debounced-high, repeat pulses for both SHALL be suppressed (counters held at 0); initial press pulses are still issued; repeating resumes with a fresh RPT_DELAY once only one remains held.
REQ-027 Buttons are independent otherwise; simultaneous pulses on different outputs are permitted.
REQ-028 No output SHALL be high for two consecutive cycles.
REQ-029 Counter arithmetic SHALL be unsigned CW-bit and must never wrap given legal parameters.

Reset
REQ-030 resetn low SHALL immediately force up, down, left, right to 0, synchronizer flops and debounced states to 0, counters to 0, FSMs to IDLE.
REQ-031 A button held through reset release SHALL be treated as a new press: one pulse after DEB_CYC+3 edges, then normal repeat.
REQ-032 Reset asserted mid-DELAY or mid-REPEAT SHALL abort without a pulse.

Verification (DEB_CYC=4, RPT_DELAY=20, RPT_RATE=8)
REQ-033 Hold btn_left from edge 1 -> left high only after edges 7, 27, 35, 43; release -> no further pulses.
REQ-034 btn_up glitches high 3 cycles, then low -> up never asserts; held 200 cycles -> exactly one up pulse.
REQ-035 btn_left and btn_right raised on the same edge and held 60 cycles -> one left and one right pulse at edge 7, nothing more; drop btn_right -> next left pulse 20 cycles after debounced release of right.
REQ-036 btn_down held, resetn pulsed low at edge 15 for 2 cycles -> down 0 during reset, next down pulse DEB_CYC+3 edges after release.
REQ-037 Random bounce on all four inputs (runs <4 cycles) over 10000 cycles -> zero pulses; no output high on consecutive cycles in any test.
